pipe_stage_elastic: RTL and testbench

- Parametrised pipeline-stage register for any inter-stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Separates control fields from datapath fields. Adds a valid/ready handshake with an optional skid entry.
- Hazard logic drives bubble insertion; branch logic drives flush.
- Control fields are forced to zero whenever the stage holds no valid instruction, so downstream decode never sees stale RegWrite/MemWrite.

---
 rtl/pipe_pkg.sv | 28 ++
 rtl/pipe_stage_elastic_slot.sv | 44 ++++
 rtl/pipe_stage_elastic.sv | 128 ++++++++++++
 tb/tb_pipe_stage_elastic.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared widths, control-bundle bit positions and the NOP control word
// for the pipeline-stage registers.
package pipe_pkg;

  // Control-bundle widths per inter-stage boundary
  localparam int IF_ID_CTRL_W  = 16;
  localparam int ID_EX_CTRL_W  = 16;
  localparam int EX_MEM_CTRL_W = 16;
  localparam int MEM_WB_CTRL_W = 16;

  // Bit positions inside a 16-bit control bundle
  localparam int CB_REG_WRITE  = 0;
  localparam int CB_MEM_TO_REG = 1;
  localparam int CB_BRANCH     = 2;
  localparam int CB_MEM_READ   = 3;
  localparam int CB_MEM_WRITE  = 4;
  localparam int CB_REG_DST    = 5;
  localparam int CB_ALU_SRC    = 6;
  localparam int CB_ALU_OP_LSB = 7;   // 2 bits: [8:7]
  localparam int CB_ALU_OP_W   = 2;
  localparam int CB_IS_JAL     = 9;
  localparam int CB_OPCODE_LSB = 10;  // 6 bits: [15:10]
  localparam int CB_OPCODE_W   = 6;

  // A bubble carries no side effects downstream
  localparam logic [ID_EX_CTRL_W-1:0] NOP_CTRL = '0;

endpackage

// File: rtl/pipe_stage_elastic_slot.sv
// One stage entry: valid flag, control bundle and data bundle.
// Clear wins over load; data survives a clear unless i_zero_data is set.
module pipe_slot #(
  parameter int CTRL_W = 16,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic              i_zero_data,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic [CTRL_W-1:0] r_ctrl;
  logic [DATA_W-1:0] r_data;

  // Entry register: reset, clear (kill), load, or hold
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_data  <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      if (i_zero_data) r_data <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_ctrl  <= i_ctrl;
      r_data  <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_ctrl  = r_ctrl;
  assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline-stage register with valid/ready handshake, optional
// skid entry, hazard bubble and branch flush. Control output is forced
// to zero whenever the head is empty.
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int CTRL_W   = ID_EX_CTRL_W,
  parameter int DATA_W   = 128,
  parameter int SKID     = 1,
  parameter int CLR_DATA = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              bubble,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  logic              w_head_valid;
  logic [CTRL_W-1:0] w_head_ctrl;
  logic [DATA_W-1:0] w_head_data;
  logic              w_skid_valid;
  logic [CTRL_W-1:0] w_skid_ctrl;
  logic [DATA_W-1:0] w_skid_data;

  logic              w_in_ready;
  logic              w_accept;
  logic              w_retire;
  logic              w_zero_data;

  logic              w_head_load;
  logic              w_head_clear;
  logic [CTRL_W-1:0] w_head_ctrl_nx;
  logic [DATA_W-1:0] w_head_data_nx;
  logic              w_skid_load;
  logic              w_skid_clear;

  assign w_accept    = in_valid & w_in_ready & ~bubble & ~flush;
  assign w_retire    = w_head_valid & out_ready & ~flush;
  assign w_zero_data = flush & (CLR_DATA != 0);

  // Slot steering: refill head from skid first, else from input; overflow to skid
  always_comb begin
    w_head_load    = 1'b0;
    w_head_clear   = flush;
    w_head_ctrl_nx = in_ctrl;
    w_head_data_nx = in_data;
    w_skid_load    = 1'b0;
    w_skid_clear   = flush;
    if (!flush) begin
      if (w_retire) begin
        if (w_skid_valid) begin
          // in_ready was low, so no accept can coincide with this move
          w_head_load    = 1'b1;
          w_head_ctrl_nx = w_skid_ctrl;
          w_head_data_nx = w_skid_data;
          w_skid_clear   = 1'b1;
        end else if (w_accept) begin
          w_head_load = 1'b1;
        end else begin
          w_head_clear = 1'b1;
        end
      end else if (w_accept) begin
        if (!w_head_valid) w_head_load = 1'b1;
        else               w_skid_load = 1'b1;
      end
    end
  end

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_head (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_head_load),
    .i_clear     (w_head_clear),
    .i_zero_data (w_zero_data),
    .i_ctrl      (w_head_ctrl_nx),
    .i_data      (w_head_data_nx),
    .o_valid     (w_head_valid),
    .o_ctrl      (w_head_ctrl),
    .o_data      (w_head_data)
  );

  generate
    if (SKID != 0) begin : g_skid
      pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_skid_load),
        .i_clear     (w_skid_clear),
        .i_zero_data (w_zero_data),
        .i_ctrl      (in_ctrl),
        .i_data      (in_data),
        .o_valid     (w_skid_valid),
        .o_ctrl      (w_skid_ctrl),
        .o_data      (w_skid_data)
      );
      // Depends only on registered skid state (plus the hazard stall)
      assign w_in_ready = ~w_skid_valid & ~bubble;
    end else begin : g_noskid
      logic w_unused_skid;
      assign w_unused_skid = &{1'b0, w_skid_load, w_skid_clear};
      assign w_skid_valid  = 1'b0;
      assign w_skid_ctrl   = '0;
      assign w_skid_data   = '0;
      assign w_in_ready    = (~w_head_valid | out_ready) & ~bubble;
    end
  endgenerate

  assign in_ready  = w_in_ready;
  assign out_valid = w_head_valid;
  assign out_ctrl  = w_head_ctrl & {CTRL_W{w_head_valid}};
  assign out_data  = w_head_data;
  assign occupancy = {1'b0, w_head_valid} + {1'b0, w_skid_valid};

  // Two entries at most: head plus skid
  always_ff @(posedge clk) begin
    if (!rst) assert (occupancy != 2'd3);
  end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: two instances (CLR_DATA=0 and 1, both
// with skid) share stimulus; a queue scoreboard tracks every beat through
// the CLR_DATA=0 instance, directed checks cover reset/bubble/flush/priority.
module tb_pipe_stage_elastic;

  localparam int CW = 16;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          bubble;
  logic          flush;
  logic          out_ready;

  logic          in_ready,  c_in_ready;
  logic          out_valid, c_out_valid;
  logic [CW-1:0] out_ctrl,  c_out_ctrl;
  logic [DW-1:0] out_data,  c_out_data;
  logic [1:0]    occupancy, c_occupancy;

  pipe_stage_elastic #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CLR_DATA(0)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .bubble(bubble), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
    .out_data(out_data), .occupancy(occupancy)
  );

  pipe_stage_elastic #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CLR_DATA(1)) u_dut_clr (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .bubble(bubble), .flush(flush),
    .out_valid(c_out_valid), .out_ready(out_ready), .out_ctrl(c_out_ctrl),
    .out_data(c_out_data), .occupancy(c_occupancy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [CW+DW-1:0] sb_q[$];
  logic [CW+DW-1:0] sb_exp;

  task automatic chk(input string tag, input logic [159:0] act, input logic [159:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d);
    in_valid = v;
    in_ctrl  = c;
    in_data  = d;
  endtask

  // Scoreboard: pop on retire, push on accept; sampled mid-cycle
  always @(negedge clk) begin
    if (rst || flush) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 160'(1), 160'(0));
        end else begin
          sb_exp = sb_q.pop_front();
          chk("sb_ctrl", 160'(out_ctrl), 160'(sb_exp[CW+DW-1:DW]));
          chk("sb_data", 160'(out_data), 160'(sb_exp[DW-1:0]));
        end
      end
      if (in_valid && in_ready && !bubble) sb_q.push_back({in_ctrl, in_data});
    end
  end

  initial begin
    rst = 1'b1; bubble = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b1, 16'hFFFF, 128'hDEAD);

    // Reset held two cycles with in_valid high
    tick(); tick();
    chk("rst_out_valid", 160'(out_valid), 160'(0));
    chk("rst_out_ctrl",  160'(out_ctrl),  160'(0));
    chk("rst_out_data",  160'(out_data),  160'(0));
    chk("rst_occupancy", 160'(occupancy), 160'(0));
    chk("rst_clr_data",  160'(c_out_data), 160'(0));
    rst = 1'b0;
    drive(1'b0, '0, '0);
    tick();
    chk("rst_in_ready",  160'(in_ready),  160'(1));
    chk("rst_occ_after", 160'(occupancy), 160'(0));

    // Streaming, 1-cycle latency, no gaps
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 16'h0041, 128'(32'hA + i));
      tick();
      chk("stream_valid", 160'(out_valid), 160'(1));
      chk("stream_ctrl",  160'(out_ctrl),  160'(16'h0041));
      chk("stream_data",  160'(out_data),  160'(32'hA + i));
      chk("stream_occ",   160'(occupancy), 160'(1));
    end
    drive(1'b0, '0, '0);
    tick();
    chk("stream_drain_valid", 160'(out_valid), 160'(0));
    chk("stream_drain_ctrl",  160'(out_ctrl),  160'(0));
    chk("stream_drain_occ",   160'(occupancy), 160'(0));

    // Backpressure into the skid entry
    drive(1'b1, 16'h0011, 128'h11);
    tick();
    chk("bp_head", 160'(out_data), 160'(8'h11));
    out_ready = 1'b0;
    drive(1'b1, 16'h0022, 128'h22);
    tick();
    chk("bp_occ_full", 160'(occupancy), 160'(2));
    chk("bp_in_ready", 160'(in_ready),  160'(0));
    chk("bp_head_hold", 160'(out_data), 160'(8'h11));
    drive(1'b0, '0, '0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_occ",   160'(occupancy), 160'(2));
      chk("bp_hold_ready", 160'(in_ready),  160'(0));
      chk("bp_hold_data",  160'(out_data),  160'(8'h11));
    end
    out_ready = 1'b1;
    tick();
    chk("bp_skid_to_head", 160'(out_data),  160'(8'h22));
    chk("bp_occ_one",      160'(occupancy), 160'(1));
    chk("bp_ready_back",   160'(in_ready),  160'(1));
    tick();
    chk("bp_empty", 160'(occupancy), 160'(0));

    // Bubble for one cycle mid-stream
    drive(1'b1, 16'h0031, 128'h31);
    tick();
    chk("bub_pre", 160'(out_data), 160'(8'h31));
    drive(1'b1, 16'h0032, 128'h32);
    bubble = 1'b1;
    #1;
    chk("bub_in_ready", 160'(in_ready), 160'(0));
    tick();
    chk("bub_valid", 160'(out_valid), 160'(0));
    chk("bub_ctrl",  160'(out_ctrl),  160'(0));
    bubble = 1'b0;
    tick();
    chk("bub_held_valid", 160'(out_valid), 160'(1));
    chk("bub_held_data",  160'(out_data),  160'(8'h32));
    drive(1'b1, 16'h0033, 128'h33);
    tick();
    chk("bub_next_data", 160'(out_data), 160'(8'h33));
    drive(1'b0, '0, '0);
    tick();

    // Flush with both entries full and a beat offered
    out_ready = 1'b0;
    drive(1'b1, 16'h0041, 128'h41);
    tick();
    drive(1'b1, 16'h0042, 128'h42);
    tick();
    chk("fl_pre_occ", 160'(occupancy), 160'(2));
    drive(1'b1, 16'h0043, 128'h43);
    flush = 1'b1;
    tick();
    chk("fl_occ",       160'(occupancy),   160'(0));
    chk("fl_valid",     160'(out_valid),   160'(0));
    chk("fl_ctrl",      160'(out_ctrl),    160'(0));
    chk("fl_data_hold", 160'(out_data),    160'(8'h41));
    chk("fl_clr_data",  160'(c_out_data),  160'(0));
    chk("fl_clr_occ",   160'(c_occupancy), 160'(0));
    flush = 1'b0;
    drive(1'b0, '0, '0);
    #1;
    chk("fl_in_ready", 160'(in_ready), 160'(1));

    // Priority: rst over flush over bubble
    drive(1'b1, 16'h0051, 128'h51);
    tick();
    chk("pri_pre_occ", 160'(occupancy), 160'(1));
    rst = 1'b1; flush = 1'b1; bubble = 1'b1; out_ready = 1'b1;
    drive(1'b1, 16'h0052, 128'h52);
    tick();
    chk("pri_rst_valid", 160'(out_valid), 160'(0));
    chk("pri_rst_occ",   160'(occupancy), 160'(0));
    chk("pri_rst_ctrl",  160'(out_ctrl),  160'(0));
    chk("pri_rst_data",  160'(out_data),  160'(0));
    rst = 1'b0; flush = 1'b0; bubble = 1'b0; out_ready = 1'b0;
    drive(1'b1, 16'h0061, 128'h61);
    tick();
    chk("pri_load_occ",  160'(occupancy), 160'(1));
    chk("pri_load_data", 160'(out_data),  160'(8'h61));
    flush = 1'b1; bubble = 1'b1;
    drive(1'b1, 16'h0062, 128'h62);
    tick();
    chk("pri_fl_occ",      160'(occupancy),  160'(0));
    chk("pri_fl_valid",    160'(out_valid),  160'(0));
    chk("pri_fl_data",     160'(out_data),   160'(8'h61));
    chk("pri_fl_clr_data", 160'(c_out_data), 160'(0));
    chk("pri_fl_bub_rdy",  160'(in_ready),   160'(0));
    flush = 1'b0; bubble = 1'b0;
    drive(1'b0, '0, '0);
    #1;
    chk("pri_ready_after", 160'(in_ready), 160'(1));
    tick();
    chk("pri_no_accept", 160'(occupancy), 160'(0));

    tick();
    chk("sb_leftover", 160'(sb_q.size()), 160'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
